// File: rtl/spart_core.sv
// SPART: bus-side UART with programmable baud divisor, one-byte RX buffer and rda/tbr handshake.
// state   | meaning
// S_IDLE  | line idle, waiting for a TX write or an RX falling edge
// S_START | start bit (TX drives 0, RX waits to confirm it at mid-bit)
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (TX drives 1, RX checks for 1)
module spart_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [15:0] DIV_RESET = 16'd10416;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0] div_q;
  logic [15:0] div_eff;
  logic [15:0] rx_start_cnt;
  logic        wr_en, rd_en, rd_buf, rd_stat, wr_buf;
  logic [7:0]  rd_data;

  state_t      tx_state;
  logic [15:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_idx;

  state_t      rx_state;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_idx;
  logic        rx_s1, rx_s2, rx_s3;
  logic        rx_stop_tick, land_ok, land_bad;
  logic [7:0]  rx_buf;
  logic        oe, fe;

  assign div_eff = (div_q < 16'd4) ? 16'd4 : div_q;
  // Synchroniser plus edge-detect flop already eat two clocks of the half-bit wait.
  assign rx_start_cnt = {1'b0, div_eff[15:1]} - 16'd2;

  assign wr_en   = iocs & ~iorw;
  assign rd_en   = iocs & iorw;
  assign wr_buf  = wr_en && (ioaddr == 2'b00);
  assign rd_buf  = rd_en && (ioaddr == 2'b00);
  assign rd_stat = rd_en && (ioaddr == 2'b01);

  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      2'b00: rd_data = rx_buf;
      2'b01: rd_data = {4'b0000, fe, oe, tbr, rda};
      2'b10: rd_data = div_q[7:0];
      2'b11: rd_data = div_q[15:8];
      default: rd_data = 8'h00;
    endcase
  end

  assign databus = rd_en ? rd_data : 8'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_RESET;
    end else if (wr_en) begin
      if (ioaddr == 2'b10) div_q[7:0]  <= databus;
      if (ioaddr == 2'b11) div_q[15:8] <= databus;
    end
  end

  // Counters reload from div_eff only at bit boundaries, so a divisor write never stretches a bit in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_shift <= 8'h00;
      tx_idx   <= 3'd0;
      txd      <= 1'b1;
      tbr      <= 1'b1;
    end else if (tx_state == S_IDLE) begin
      if (wr_buf) begin
        tx_shift <= databus;
        tx_cnt   <= div_eff - 16'd1;
        txd      <= 1'b0;
        tbr      <= 1'b0;
        tx_state <= S_START;
      end
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= div_eff - 16'd1;
      case (tx_state)
        S_START: begin
          txd      <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_idx   <= 3'd0;
          tx_state <= S_DATA;
        end
        S_DATA: begin
          if (tx_idx == 3'd7) begin
            txd      <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= tx_idx + 3'd1;
          end
        end
        default: begin
          tbr      <= 1'b1;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_stop_tick = (rx_state == S_STOP) && (rx_cnt == 16'd0);
  assign land_ok      = rx_stop_tick && rx_s2;
  assign land_bad     = rx_stop_tick && !rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_shift <= 8'h00;
      rx_idx   <= 3'd0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= rx_start_cnt;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rx_s2) begin
            rx_state <= S_IDLE;
          end else begin
            rx_cnt   <= div_eff - 16'd1;
            rx_idx   <= 3'd0;
            rx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= div_eff - 16'd1;
            if (rx_idx == 3'd7) rx_state <= S_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end
        end
        default: begin
          if (rx_cnt != 16'd0) rx_cnt   <= rx_cnt - 16'd1;
          else                 rx_state <= S_IDLE;
        end
      endcase
    end
  end

  // A landing byte wins over a same-cycle buffer read; that read still returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf <= 8'h00;
      rda    <= 1'b0;
      oe     <= 1'b0;
      fe     <= 1'b0;
    end else begin
      if (land_ok) rx_buf <= rx_shift;

      if (land_ok)     rda <= 1'b1;
      else if (rd_buf) rda <= 1'b0;

      if (land_ok && rda && !rd_buf) oe <= 1'b1;
      else if (rd_buf || rd_stat)    oe <= 1'b0;

      if (land_bad)     fe <= 1'b1;
      else if (rd_stat) fe <= 1'b0;
    end
  end

endmodule
